// File: rtl/culsans_soc_top.sv
// Culsans SoC shell: one request bus decoded into main SRAM, a CLINT-lite timer and a sticky exit register.
// Define CULSANS_XILINX_SRAM_EN for a block-RAM style SRAM with an output register (2-cycle responses).
module culsans_soc_top #(
  parameter int unsigned NUM_WORDS   = 4096,
  parameter logic [63:0] DRAMBase    = 64'h8000_0000,
  parameter logic [63:0] BootAddress = 64'h8006_0000,
  parameter logic [63:0] ExitAddr    = 64'h1000_0000,
  parameter logic [63:0] ClintBase   = 64'h0200_0000
) (
  input  logic        clk_i,
  input  logic        rst,
  input  logic        rtc_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [63:0] addr_i,
  input  logic [63:0] wdata_i,
  input  logic [7:0]  be_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [63:0] rdata_o,
  output logic        err_o,
  output logic [63:0] boot_addr_o,
  output logic        timer_irq_o,
  output logic [31:0] exit_o
);
  localparam int unsigned AW = $clog2(NUM_WORDS);
  localparam logic [63:0] SramEnd      = DRAMBase + 64'(NUM_WORDS) * 64'd8;
  localparam logic [63:0] MtimecmpAddr = ClintBase + 64'h4000;
  localparam logic [63:0] MtimeAddr    = ClintBase + 64'hBFF8;

  logic [63:0]   addrAligned;
  logic [63:0]   sramOffset;
  logic [AW-1:0] sramIdx;
  logic [63:0]   beMask;
  logic          sramHit, cmpHit, mtimeHit, exitHit, anyHit;
  logic          wrEn, rdEn;
  logic          unusedBits;

  assign gnt_o       = req_i;
  assign boot_addr_o = BootAddress;

  assign addrAligned = {addr_i[63:3], 3'b000};
  assign sramOffset  = addrAligned - DRAMBase;
  assign sramIdx     = sramOffset[AW+2:3];
  assign sramHit     = (addrAligned >= DRAMBase) && (addrAligned < SramEnd);
  assign cmpHit      = (addrAligned == MtimecmpAddr);
  assign mtimeHit    = (addrAligned == MtimeAddr);
  assign exitHit     = (addrAligned == ExitAddr);
  assign anyHit      = sramHit | cmpHit | mtimeHit | exitHit;
  assign wrEn        = req_i & we_i;
  assign rdEn        = req_i & ~we_i;
  assign unusedBits  = ^{addr_i[2:0], sramOffset[63:AW+3], sramOffset[2:0]};

  always_comb begin
    beMask = '0;
    for (int b = 0; b < 8; b++) beMask[b*8 +: 8] = {8{be_i[b]}};
  end

  // Timer and exit state; rtc_i is synchronized and its rising edge registered before it counts.
  logic [1:0]  rtcSync_q;
  logic        rtcPrev_q, rtcRise_q;
  logic [63:0] mtime_q, mtimecmp_q, mtimecmp_d;
  logic [31:0] exit_q, exit_d;
  logic        timerIrq_q;

  assign mtimecmp_d = (mtimecmp_q & ~beMask) | (wdata_i & beMask);
  assign exit_d     = (exit_q & ~beMask[31:0]) | (wdata_i[31:0] & beMask[31:0]);

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      rtcSync_q  <= 2'b00;
      rtcPrev_q  <= 1'b0;
      rtcRise_q  <= 1'b0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      exit_q     <= '0;
      timerIrq_q <= 1'b0;
    end else begin
      rtcSync_q  <= {rtcSync_q[0], rtc_i};
      rtcPrev_q  <= rtcSync_q[1];
      rtcRise_q  <= rtcSync_q[1] & ~rtcPrev_q;
      if (rtcRise_q) mtime_q <= mtime_q + 64'd1;
      if (wrEn && cmpHit) mtimecmp_q <= mtimecmp_d;
      if (wrEn && exitHit && !exit_q[0]) exit_q <= exit_d;
      timerIrq_q <= (mtime_q >= mtimecmp_q);
    end
  end

  assign timer_irq_o = timerIrq_q;
  assign exit_o      = exit_q;

  // Main SRAM: byte-lane writes, registered read port, contents never reset.
  logic [63:0] mem [NUM_WORDS];
  logic [63:0] sramRdata_q;

  always_ff @(posedge clk_i) begin
    if (wrEn && sramHit) begin
      for (int b = 0; b < 8; b++) begin
        if (be_i[b]) mem[sramIdx][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    if (rdEn && sramHit) sramRdata_q <= mem[sramIdx];
  end

  logic        rsp1Valid_d, rsp1Err_d, rsp1Sram_d;
  logic [63:0] rsp1Rdata_d;
  logic        rsp1Valid_q, rsp1Err_q, rsp1Sram_q;
  logic [63:0] rsp1Rdata_q;
  logic [63:0] rsp1Rdata;

  always_comb begin
    rsp1Valid_d = req_i;
    rsp1Err_d   = req_i & ~anyHit;
    rsp1Sram_d  = 1'b0;
    rsp1Rdata_d = '0;
    if (rdEn) begin
      if (sramHit)       rsp1Sram_d  = 1'b1;
      else if (cmpHit)   rsp1Rdata_d = mtimecmp_q;
      else if (mtimeHit) rsp1Rdata_d = mtime_q;
      else if (exitHit)  rsp1Rdata_d = {32'b0, exit_q};
    end
  end

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      rsp1Valid_q <= 1'b0;
      rsp1Err_q   <= 1'b0;
      rsp1Sram_q  <= 1'b0;
      rsp1Rdata_q <= '0;
    end else begin
      rsp1Valid_q <= rsp1Valid_d;
      rsp1Err_q   <= rsp1Err_d;
      rsp1Sram_q  <= rsp1Sram_d;
      rsp1Rdata_q <= rsp1Rdata_d;
    end
  end

  assign rsp1Rdata = rsp1Sram_q ? sramRdata_q : rsp1Rdata_q;

`ifdef CULSANS_XILINX_SRAM_EN
  // Output register of the block RAM; every target shares it so responses stay in order.
  logic        rsp2Valid_q, rsp2Err_q;
  logic [63:0] rsp2Rdata_q;

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      rsp2Valid_q <= 1'b0;
      rsp2Err_q   <= 1'b0;
      rsp2Rdata_q <= '0;
    end else begin
      rsp2Valid_q <= rsp1Valid_q;
      rsp2Err_q   <= rsp1Err_q;
      rsp2Rdata_q <= rsp1Rdata;
    end
  end

  assign rvalid_o = rsp2Valid_q;
  assign err_o    = rsp2Err_q;
  assign rdata_o  = rsp2Rdata_q;
`else
  assign rvalid_o = rsp1Valid_q;
  assign err_o    = rsp1Err_q;
  assign rdata_o  = rsp1Rdata;
`endif

endmodule

// File: tb/tb_culsans_soc_top.sv
// Directed, table-driven bench for culsans_soc_top plus hand-written timer, back-to-back and reset sequences.
module tb_culsans_soc_top;
  localparam int unsigned   NW    = 65536;
  localparam logic [63:0]   DRAM  = 64'h8000_0000;
  localparam logic [63:0]   BOOT  = 64'h8006_0000;
  localparam logic [63:0]   EXITA = 64'h1000_0000;
  localparam logic [63:0]   CLINT = 64'h0200_0000;
  localparam logic [63:0]   MCMP  = CLINT + 64'h4000;
  localparam logic [63:0]   MTIME = CLINT + 64'hBFF8;
`ifdef CULSANS_XILINX_SRAM_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk_i = 1'b0;
  logic        rst, rtc_i, req_i, we_i;
  logic [63:0] addr_i, wdata_i;
  logic [7:0]  be_i;
  logic        gnt_o, rvalid_o, err_o, timer_irq_o;
  logic [63:0] rdata_o, boot_addr_o;
  logic [31:0] exit_o;

  int errors = 0;
  int checks = 0;

  culsans_soc_top #(
    .NUM_WORDS(NW), .DRAMBase(DRAM), .BootAddress(BOOT), .ExitAddr(EXITA), .ClintBase(CLINT)
  ) dut (
    .clk_i(clk_i), .rst(rst), .rtc_i(rtc_i), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .boot_addr_o(boot_addr_o), .timer_irq_o(timer_irq_o), .exit_o(exit_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic        expErr;
    logic [63:0] expRdata;
    logic [31:0] expExit;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [7:0] be, input logic expErr, input logic [63:0] expRdata,
                              input logic [31:0] expExit);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
    v.expErr = expErr; v.expRdata = expRdata; v.expExit = expExit;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one request and returns at the negedge where its response is due.
  task automatic applyStimulus(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [7:0] be);
    @(negedge clk_i);
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata; be_i = be;
    #1 checkOutput("gnt", 64'(gnt_o), 64'd1);
    @(negedge clk_i);
    req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
    repeat (LAT - 1) @(negedge clk_i);
  endtask

  task automatic checkResponse(input string tag, input logic expErr, input logic [63:0] expRdata);
    checkOutput({tag, " rvalid"}, 64'(rvalid_o), 64'd1);
    checkOutput({tag, " err"}, 64'(err_o), 64'(expErr));
    checkOutput({tag, " rdata"}, rdata_o, expRdata);
  endtask

  task automatic rtcPeriod();
    @(negedge clk_i); rtc_i = 1'b1;
    repeat (6) @(negedge clk_i);
    rtc_i = 1'b0;
    repeat (6) @(negedge clk_i);
  endtask

  logic [63:0] b2bAddr [3];
  logic        b2bWe   [3];
  logic [63:0] b2bData [3];
  logic [63:0] b2bExp  [3];
  int          lateValid;

  initial begin
    vecs[0]  = mk(1'b1, DRAM + 64'h60000, 64'hDEAD_BEEF_0123_4567, 8'hFF, 1'b0, 64'h0, 32'h0);
    vecs[1]  = mk(1'b1, DRAM + 64'h60000, 64'h0000_0000_0000_00AA, 8'h01, 1'b0, 64'h0, 32'h0);
    vecs[2]  = mk(1'b0, DRAM + 64'h60000, 64'h0, 8'h00, 1'b0, 64'hDEAD_BEEF_0123_45AA, 32'h0);
    vecs[3]  = mk(1'b0, DRAM + 64'h60005, 64'h0, 8'h00, 1'b0, 64'hDEAD_BEEF_0123_45AA, 32'h0);
    vecs[4]  = mk(1'b1, DRAM + 64'h7FFF8, 64'h1111_2222_3333_4444, 8'hFF, 1'b0, 64'h0, 32'h0);
    vecs[5]  = mk(1'b0, DRAM + 64'h7FFF8, 64'h0, 8'h00, 1'b0, 64'h1111_2222_3333_4444, 32'h0);
    vecs[6]  = mk(1'b0, DRAM + 64'h80000, 64'h0, 8'h00, 1'b1, 64'h0, 32'h0);
    vecs[7]  = mk(1'b0, DRAM - 64'h8, 64'h0, 8'h00, 1'b1, 64'h0, 32'h0);
    vecs[8]  = mk(1'b0, 64'h1000, 64'h0, 8'h00, 1'b1, 64'h0, 32'h0);
    vecs[9]  = mk(1'b1, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1, 64'h0, 32'h0);
    vecs[10] = mk(1'b1, EXITA, 64'h0000_0000_FFFF_0200, 8'h02, 1'b0, 64'h0, 32'h0000_0200);
    vecs[11] = mk(1'b1, EXITA, 64'h0000_0000_0000_0003, 8'h0F, 1'b0, 64'h0, 32'h3);
    vecs[12] = mk(1'b1, EXITA, 64'h0, 8'h0F, 1'b0, 64'h0, 32'h3);
    vecs[13] = mk(1'b0, EXITA, 64'h0, 8'h00, 1'b0, 64'h3, 32'h3);
    vecs[14] = mk(1'b1, MTIME, 64'h1234, 8'hFF, 1'b0, 64'h0, 32'h3);
    vecs[15] = mk(1'b0, MTIME, 64'h0, 8'h00, 1'b0, 64'h0, 32'h3);
    vecs[16] = mk(1'b0, MCMP, 64'h0, 8'h00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h3);

    rst = 1'b0; rtc_i = 1'b0; req_i = 1'b0; we_i = 1'b0;
    addr_i = '0; wdata_i = '0; be_i = '0;
    repeat (3) @(negedge clk_i);
    checkOutput("reset gnt", 64'(gnt_o), 64'd0);
    checkOutput("reset rvalid", 64'(rvalid_o), 64'd0);
    checkOutput("reset rdata", rdata_o, 64'd0);
    checkOutput("reset err", 64'(err_o), 64'd0);
    checkOutput("reset exit", 64'(exit_o), 64'd0);
    checkOutput("reset irq", 64'(timer_irq_o), 64'd0);
    checkOutput("boot addr", boot_addr_o, 64'h8006_0000);
    rst = 1'b1;
    repeat (2) @(negedge clk_i);
    checkOutput("post-reset rvalid", 64'(rvalid_o), 64'd0);
    checkOutput("post-reset irq", 64'(timer_irq_o), 64'd0);

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      checkResponse($sformatf("vec%0d", i), vecs[i].expErr, vecs[i].expRdata);
      checkOutput($sformatf("vec%0d exit", i), 64'(exit_o), 64'(vecs[i].expExit));
      @(negedge clk_i);
      checkOutput($sformatf("vec%0d single rvalid", i), 64'(rvalid_o), 64'd0);
    end

    // Timer: compare value 3 must fire exactly one cycle after the third counted rtc edge.
    applyStimulus(1'b1, MCMP, 64'd3, 8'hFF);
    checkResponse("mtimecmp wr", 1'b0, 64'h0);
    rtcPeriod();
    rtcPeriod();
    checkOutput("irq after 2 rtc", 64'(timer_irq_o), 64'd0);
    @(negedge clk_i); rtc_i = 1'b1;
    repeat (4) @(negedge clk_i);
    checkOutput("irq before edge 3", 64'(timer_irq_o), 64'd0);
    @(negedge clk_i);
    checkOutput("irq at edge 3", 64'(timer_irq_o), 64'd1);
    repeat (2) @(negedge clk_i);
    rtc_i = 1'b0;
    repeat (6) @(negedge clk_i);
    rtcPeriod();
    rtcPeriod();
    applyStimulus(1'b0, MTIME, 64'h0, 8'h00);
    checkResponse("mtime after 5 rtc", 1'b0, 64'd5);
    checkOutput("irq held", 64'(timer_irq_o), 64'd1);
    applyStimulus(1'b1, MCMP, 64'hFFFF_FFFF_FFFF_FF07, 8'h01);
    checkResponse("mtimecmp be wr", 1'b0, 64'h0);
    applyStimulus(1'b0, MCMP, 64'h0, 8'h00);
    checkResponse("mtimecmp merged", 1'b0, 64'd7);
    repeat (2) @(negedge clk_i);
    checkOutput("irq cleared", 64'(timer_irq_o), 64'd0);

    // Back-to-back read, write, read: three in-order responses on consecutive cycles.
    b2bAddr[0] = DRAM + 64'h60000; b2bWe[0] = 1'b0; b2bData[0] = '0; b2bExp[0] = 64'hDEAD_BEEF_0123_45AA;
    b2bAddr[1] = DRAM + 64'h60008; b2bWe[1] = 1'b1; b2bData[1] = 64'h0F1E_2D3C_4B5A_6978; b2bExp[1] = '0;
    b2bAddr[2] = DRAM + 64'h60008; b2bWe[2] = 1'b0; b2bData[2] = '0; b2bExp[2] = 64'h0F1E_2D3C_4B5A_6978;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      if (c >= LAT && c - LAT < 3)
        checkResponse($sformatf("b2b rsp%0d", c - LAT), 1'b0, b2bExp[c - LAT]);
      else if (c > 0)
        checkOutput($sformatf("b2b idle c%0d", c), 64'(rvalid_o), 64'd0);
      if (c < 3) begin
        req_i = 1'b1; we_i = b2bWe[c]; addr_i = b2bAddr[c]; wdata_i = b2bData[c]; be_i = 8'hFF;
      end else begin
        req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
      end
    end

    // Reset while a read is in flight: no response may surface afterwards.
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b0; addr_i = DRAM + 64'h60000;
    @(posedge clk_i);
    #1 rst = 1'b0;
    req_i = 1'b0; addr_i = '0;
    repeat (2) @(negedge clk_i);
    rst = 1'b1;
    lateValid = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      if (rvalid_o !== 1'b0) lateValid++;
    end
    checkOutput("no rvalid after reset", 64'(lateValid), 64'd0);
    checkOutput("exit cleared", 64'(exit_o), 64'd0);
    checkOutput("irq after reset", 64'(timer_irq_o), 64'd0);
    applyStimulus(1'b0, MTIME, 64'h0, 8'h00);
    checkResponse("mtime reset", 1'b0, 64'd0);
    applyStimulus(1'b0, MCMP, 64'h0, 8'h00);
    checkResponse("mtimecmp reset", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(1'b0, DRAM + 64'h60008, 64'h0, 8'h00);
    checkResponse("sram kept", 1'b0, 64'h0F1E_2D3C_4B5A_6978);
    applyStimulus(1'b1, EXITA, 64'd5, 8'h0F);
    checkResponse("exit rewrite", 1'b0, 64'h0);
    checkOutput("exit unlocked", 64'(exit_o), 64'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/culsans_soc_top.md
# culsans_soc_top

Single-port SoC shell for the Culsans platform. It decodes one core-side memory request bus into three targets: a word-addressed main SRAM at DRAMBase, a CLINT-lite timer clocked by the RTC input, and a sticky 32-bit exit register. It exports the boot address and the exit value. Cores and their interconnect sit outside the block and connect through the request bus.

## Interface

Parameters:
- NUM_WORDS, 4096: SRAM depth in 64-bit words; power of two.
- DRAMBase, 64'h8000_0000: SRAM base address.
- BootAddress, 64'h8006_0000: value driven on boot_addr_o.
- ExitAddr, 64'h1000_0000: exit register address.
- ClintBase, 64'h0200_0000: CLINT-lite base address.

Ports:
- clk_i  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- rtc_i  input  1  real-time clock, asynchronous to clk_i.
- req_i  input  1  request valid.
- we_i  input  1  1 = write, 0 = read.
- addr_i  input  64  byte address; bits [2:0] ignored.
- wdata_i  input  64  write data.
- be_i  input  8  byte enables for writes.
- gnt_o  output  1  request accepted.
- rvalid_o  output  1  response valid, one per accepted request, reads and writes.
- rdata_o  output  64  read data; 0 for writes and errors.
- err_o  output  1  response error, qualified by rvalid_o.
- boot_addr_o  output  64  constant BootAddress.
- timer_irq_o  output  1  machine timer interrupt.
- exit_o  output  32  exit value.

## Operation

- gnt_o = req_i. Every request is accepted in the cycle it is presented.
- Address decode on addr_i, aligned to 8 bytes:
  - SRAM: DRAMBase ≤ addr < DRAMBase + NUM_WORDS*8. Word index = (addr − DRAMBase) >> 3. Writes update only the bytes selected by be_i.
  - mtimecmp: ClintBase + 0x4000. 64-bit read/write, byte-enable merged.
  - mtime: ClintBase + 0xBFF8. Read-only; writes are ignored with no error.
  - exit: ExitAddr. A write loads be_i[3:0]-selected bytes of wdata_i[31:0] into exit_o while exit_o[0] = 0. Once exit_o[0] = 1, the register is locked until reset. A read returns zero-extended exit_o.
  - Any other address: no side effect, response carries err_o = 1 and rdata_o = 0.
- RTC handling:
  - rtc_i passes through a 2-flop synchronizer into clk_i.
  - mtime increments by 1 per synchronized rising edge and wraps at 2^64 − 1 → 0.
- timer_irq_o = (mtime ≥ mtimecmp), registered.
- SRAM contents are not reset. All other state is reset.

## Timing

- Reset values:
  - gnt_o = 0 (tracks req_i).
  - rvalid_o = 0, rdata_o = 0, err_o = 0.
  - exit_o = 0, mtime = 0.
  - mtimecmp = all-ones, so timer_irq_o = 0.
  - boot_addr_o = BootAddress at all times.
- Read/write response latency L is 1 cycle by default, or 2 with the configuration macro (see Configuration). The response follows the grant by exactly L cycles. Requests may issue back to back. Responses return in order, one per cycle.
- A write's effect is visible to a read granted in the next cycle.
- An rtc_i edge reaches mtime 3 clk_i cycles after it is sampled (2 synchronizer flops + edge detect). timer_irq_o reflects mtime/mtimecmp one cycle later.
- Reset asserted mid-transaction drops all in-flight responses. No rvalid_o appears after reset release for pre-reset requests.

## Configuration

- CULSANS_XILINX_SRAM_EN defined: the SRAM uses a registered output, matching a vendor block RAM. L = 2 for all targets; CLINT, exit and error responses are delayed to stay in order.
- CULSANS_XILINX_SRAM_EN undefined: a behavioural array is used. L = 1 for all targets.

## Test plan

- Reset release → exit_o = 0, timer_irq_o = 0, boot_addr_o = 64'h8006_0000, no rvalid_o.
- Write 64'hDEAD_BEEF_0123_4567 to 0x8006_0000 with be = 8'hFF. Then write be = 8'h01, data 0xAA. Then read 0x8006_0000 → rdata_o = 64'hDEAD_BEEF_0123_45AA, rvalid_o L cycles after grant, err_o = 0.
- Write 32'h0000_0003 to ExitAddr → exit_o = 3. A later write of 0 → exit_o stays 3.
- Toggle rtc_i 5 full periods → mtime read = 5.
- Write mtimecmp = 3 → timer_irq_o rises after the third synchronized rtc edge, plus one cycle.
- Read 0x0000_1000 (unmapped) → rvalid_o with err_o = 1, rdata_o = 0. Back-to-back read, write, read to SRAM → three consecutive in-order responses.
